// File: rtl/pc_wd_display_scanner_pkg.sv
// rtl/pc_wd_display_scanner_pkg.sv - shared constants for the PC/WriteData display scanner
package pc_wd_display_scanner_pkg;

  localparam int NUM_DIGITS = 8;

  // All segments dark / all digits disabled (active-low display).
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} patterns; entry N is the glyph for hex digit N.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/pc_wd_display_scanner_if.sv
// rtl/pc_wd_display_scanner_if.sv - processor debug inputs and display pins
interface pc_wd_display_scanner_if;

  logic [31:0] PCValue;
  logic [31:0] WriteData;
  logic        Page;
  logic        Freeze;
  logic [7:0]  An;
  logic [6:0]  Seg;
  logic        Dp;

  // Processor/board side: supplies values, observes the display pins.
  modport master (
    output PCValue, WriteData, Page, Freeze,
    input  An, Seg, Dp
  );

  // Scanner side.
  modport slave (
    input  PCValue, WriteData, Page, Freeze,
    output An, Seg, Dp
  );

endinterface

// File: rtl/pc_wd_display_scanner_hex_to_seg7.sv
// rtl/pc_wd_display_scanner_hex_to_seg7.sv - hex nibble to active-low seven-segment decoder
module hex_to_seg7
  import pc_wd_display_scanner_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/pc_wd_display_scanner.sv
// rtl/pc_wd_display_scanner.sv - 8-digit multiplexed display of PC and WriteData halves
module pc_wd_display_scanner
  import pc_wd_display_scanner_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input logic                      Clk,
  input logic                      Rst,
  pc_wd_display_scanner_if.slave   disp
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      pc_s_q, pc_s_d;
  logic [31:0]      wd_s_q, wd_s_d;
  logic             page_s_q, page_s_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             tick;
  logic [15:0]      pc_half, wd_half, sel_half;
  logic [3:0]       nibble;

  assign tick = (div_q == DIV_LAST);

  hex_to_seg7 u_dec (
    .nibble_i (nibble),
    .seg_o    (seg_d)
  );

  // Next state: divider, digit index, frame-boundary snapshot and nibble select.
  always_comb begin
    div_d    = tick ? '0 : div_q + 1'b1;
    idx_d    = tick ? idx_q + 3'd1 : idx_q;
    pc_s_d   = pc_s_q;
    wd_s_d   = wd_s_q;
    page_s_d = page_s_q;
    // Only the frame boundary samples the inputs, so a frame never tears.
    if (tick && (idx_q == 3'd7) && !disp.Freeze) begin
      pc_s_d   = disp.PCValue;
      wd_s_d   = disp.WriteData;
      page_s_d = disp.Page;
    end

    pc_half  = page_s_q ? pc_s_q[31:16] : pc_s_q[15:0];
    wd_half  = page_s_q ? wd_s_q[31:16] : wd_s_q[15:0];
    sel_half = idx_q[2] ? pc_half : wd_half;
    nibble   = sel_half[3:0];
    case (idx_q[1:0])
      2'd0: nibble = sel_half[3:0];
      2'd1: nibble = sel_half[7:4];
      2'd2: nibble = sel_half[11:8];
      2'd3: nibble = sel_half[15:12];
      default: nibble = sel_half[3:0];
    endcase

    an_d = ~(8'b1 << idx_q);
    dp_d = (idx_q != 3'd4);
  end

  // State and output registers; outputs trail idx/snapshot by one cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      div_q    <= '0;
      idx_q    <= '0;
      pc_s_q   <= '0;
      wd_s_q   <= '0;
      page_s_q <= 1'b0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b1;
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      pc_s_q   <= pc_s_d;
      wd_s_q   <= wd_s_d;
      page_s_q <= page_s_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign disp.An  = an_q;
  assign disp.Seg = seg_q;
  assign disp.Dp  = dp_q;

endmodule

// File: tb/tb_pc_wd_display_scanner.sv
// tb/tb_pc_wd_display_scanner.sv - directed self-checking bench for the display scanner
module tb_pc_wd_display_scanner;

  logic clk;
  logic rst;
  int   k;
  int   passed;
  int   total;

  pc_wd_display_scanner_if dif ();

  pc_wd_display_scanner #(.REFRESH_DIV(4)) dut (
    .Clk  (clk),
    .Rst  (rst),
    .disp (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; k counts edges since reset release, sampling on the falling edge.
  task automatic cyc();
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  function automatic logic [7:0] exp_an(int kk);
    int d;
    d = ((kk - 1) / 4) % 8;
    return ~(8'd1 << d);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    dif.PCValue = 32'h0; dif.WriteData = 32'h0; dif.Page = 1'b0; dif.Freeze = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if (dif.An !== 8'hFF || dif.Seg !== 7'h7F || dif.Dp !== 1'b1)
        $display("FAIL reset_hold cyc=%0d An=%h Seg=%h Dp=%b expected An=ff Seg=7f Dp=1",
                 i, dif.An, dif.Seg, dif.Dp);
      else passed++;
    end
    rst = 1'b0;
    k = 0;
    cyc();
    total++;
    if (dif.An !== 8'hFE || dif.Seg !== 7'h40 || dif.Dp !== 1'b1)
      $display("FAIL reset_first An=%h Seg=%h Dp=%b expected An=fe Seg=40 Dp=1",
               dif.An, dif.Seg, dif.Dp);
    else passed++;
  endtask

  task automatic test_scan_order();
    int d;
    logic edp;
    while (k < 31) begin
      cyc();
      d = ((k - 1) / 4) % 8;
      edp = (d == 4) ? 1'b0 : 1'b1;
      total++;
      if (dif.An !== exp_an(k) || dif.Seg !== 7'h40 || dif.Dp !== edp)
        $display("FAIL scan_order k=%0d An=%h Seg=%h Dp=%b expected An=%h Seg=40 Dp=%b",
                 k, dif.An, dif.Seg, dif.Dp, exp_an(k), edp);
      else passed++;
    end
  endtask

  task automatic test_snapshot();
    logic [6:0] f1 [8];
    logic [6:0] f2 [8];
    logic [6:0] e;
    int d;
    logic edp;
    f1 = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    f2 = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h40, 7'h79, 7'h40, 7'h40};
    dif.PCValue = 32'h00400010; dif.WriteData = 32'h0000ABCD; dif.Page = 1'b0;
    while (k < 47) begin
      cyc();
      d = ((k - 1) / 4) % 8;
      edp = (d == 4) ? 1'b0 : 1'b1;
      e = (k <= 32) ? f1[d] : f2[d];
      total++;
      if (dif.An !== exp_an(k) || dif.Seg !== e || dif.Dp !== edp)
        $display("FAIL snapshot k=%0d An=%h Seg=%h Dp=%b expected An=%h Seg=%h Dp=%b",
                 k, dif.An, dif.Seg, dif.Dp, exp_an(k), e, edp);
      else passed++;
    end
  endtask

  task automatic test_page_midframe();
    logic [6:0] f2 [8];
    logic [6:0] f3 [8];
    logic [6:0] e;
    int d;
    logic edp;
    f2 = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h40, 7'h79, 7'h40, 7'h40};
    f3 = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h40, 7'h40};
    dif.Page = 1'b1;
    while (k < 96) begin
      cyc();
      d = ((k - 1) / 4) % 8;
      edp = (d == 4) ? 1'b0 : 1'b1;
      e = (k <= 64) ? f2[d] : f3[d];
      total++;
      if (dif.An !== exp_an(k) || dif.Seg !== e || dif.Dp !== edp)
        $display("FAIL page_midframe k=%0d An=%h Seg=%h Dp=%b expected An=%h Seg=%h Dp=%b",
                 k, dif.An, dif.Seg, dif.Dp, exp_an(k), e, edp);
      else passed++;
      if (k == 90) dif.Page = 1'b0;
    end
  endtask

  task automatic test_freeze();
    logic [6:0] fa [8];
    logic [6:0] fb [8];
    logic [6:0] e;
    int d;
    logic edp;
    fa = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h40, 7'h79, 7'h40, 7'h40};
    fb = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h40, 7'h79, 7'h40, 7'h40};
    while (k < 181) begin
      cyc();
      d = ((k - 1) / 4) % 8;
      edp = (d == 4) ? 1'b0 : 1'b1;
      e = (k <= 160) ? fa[d] : fb[d];
      total++;
      if (dif.An !== exp_an(k) || dif.Seg !== e || dif.Dp !== edp)
        $display("FAIL freeze k=%0d An=%h Seg=%h Dp=%b expected An=%h Seg=%h Dp=%b",
                 k, dif.An, dif.Seg, dif.Dp, exp_an(k), e, edp);
      else passed++;
      if (k == 100) begin
        dif.Freeze = 1'b1;
        dif.WriteData = 32'h00001234;
      end
      if (k == 140) dif.Freeze = 1'b0;
    end
  endtask

  task automatic test_midframe_reset();
    int d;
    logic edp;
    rst = 1'b1;
    cyc();
    total++;
    if (dif.An !== 8'hFF || dif.Seg !== 7'h7F || dif.Dp !== 1'b1)
      $display("FAIL midframe_reset_edge An=%h Seg=%h Dp=%b expected An=ff Seg=7f Dp=1",
               dif.An, dif.Seg, dif.Dp);
    else passed++;
    rst = 1'b0;
    k = 0;
    while (k < 32) begin
      cyc();
      d = ((k - 1) / 4) % 8;
      edp = (d == 4) ? 1'b0 : 1'b1;
      total++;
      if (dif.An !== exp_an(k) || dif.Seg !== 7'h40 || dif.Dp !== edp)
        $display("FAIL midframe_reset_scan k=%0d An=%h Seg=%h Dp=%b expected An=%h Seg=40 Dp=%b",
                 k, dif.An, dif.Seg, dif.Dp, exp_an(k), edp);
      else passed++;
    end
    cyc();
    total++;
    if (dif.An !== 8'hFE || dif.Seg !== 7'h19)
      $display("FAIL midframe_reset_reload An=%h Seg=%h expected An=fe Seg=19",
               dif.An, dif.Seg);
    else passed++;
  endtask

  initial begin
    k = 0;
    passed = 0;
    total = 0;
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_scan_order();
    test_snapshot();
    test_page_midframe();
    test_freeze();
    test_midframe_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_wd_display_scanner.md
Name: pc_wd_display_scanner

Overview:
Board-level display stage that sits directly downstream of the processor top level and consumes its WriteData and PCValue debug outputs. It drives an 8-digit, common-anode, time-multiplexed seven-segment display:
- Right four digits: a 16-bit half of WriteData.
- Left four digits: a 16-bit half of PCValue.
- Inputs are snapshotted once per refresh frame, so the display never tears mid-scan.

Parameters:
REFRESH_DIV, 100000, clock cycles each digit is driven (legal range >= 2)
NUM_DIGITS, 8, digit count; fixed and not overridable

Ports:
Clk  input  1  system clock
Rst  input  1  synchronous, active-high reset
PCValue  input  32  program counter from processor top level
WriteData  input  32  register-file write data from processor top level
Page  input  1  0 = show bits [15:0], 1 = show bits [31:16] of both values
Freeze  input  1  1 = hold current snapshot; scanning continues
An  output  8  digit enables, active-low, An[0] = rightmost digit
Seg  output  7  segments {g,f,e,d,c,b,a}, active-low
Dp  output  1  decimal point, active-low

Behaviour:
- Reset (sampled on the Clk edge with Rst=1):
  - Divider counter = 0, digit index idx = 0.
  - Snapshot registers {pc_s, wd_s, page_s} = 0.
  - An = 8'hFF, Seg = 7'h7F, Dp = 1.
- Divider:
  - div counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick = (div == REFRESH_DIV-1).
- Digit index:
  - On tick, idx <= idx+1 modulo 8 (7 wraps to 0).
  - Otherwise idx holds.
- Snapshot:
  - On tick with idx == 7 and Freeze == 0: pc_s <= PCValue, wd_s <= WriteData, page_s <= Page.
  - Frame period is 8*REFRESH_DIV cycles.
  - Freeze == 1 on that edge: snapshot holds. Freeze at any other time has no effect.
  - Page is honoured only through page_s; a Page change mid-frame takes effect at the next frame boundary.
- Nibble select. Let h = page_s ? upper 16 bits : lower 16 bits.
  - idx 0..3 selects wd half nibble idx.
  - idx 4..7 selects pc half nibble idx-4.
- Outputs are registered every cycle (one-cycle latency from idx/snapshot):
  - An <= ~(8'b1 << idx).
  - Seg <= decode(nibble).
  - Dp <= (idx == 4) ? 0 : 1; this is the separator between PC and data.
- First cycle after Rst deasserts: An = 8'hFE, Seg = 7'b1000000 (digit 0 showing zero snapshot).
- Hex decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Exactly one An bit is low at all times after the first post-reset cycle. No all-off gap between digits.
- Reset mid-frame: all state returns to reset values on that edge. The snapshot is cleared, not retained.
- Input changes between frame boundaries are never visible on Seg.

Decomposition:
- Shared package:
  - NUM_DIGITS.
  - The 16-entry active-low segment constant table.
  - Constants SEG_BLANK = 7'h7F and AN_OFF = 8'hFF.
- One natural combinational sub-module: hex_to_seg7 (4-bit nibble in, 7-bit active-low segments out).
- Divider, index, snapshot and output registers stay in the parent.

Test Plan:
All scenarios use REFRESH_DIV=4 (frame = 32 cycles) and release Rst at cycle 0.
1. Reset check: hold Rst for 3 cycles -> An=8'hFF, Seg=7'h7F, Dp=1 throughout. Cycle 1 after release -> An=8'hFE, Seg=1000000.
2. Scan order: idle inputs. An steps FE,FD,FB,F7,EF,DF,BF,7F every 4 cycles, then wraps to FE. Dp=0 only while An=8'hEF.
3. Snapshot content: PCValue=32'h00400010, WriteData=32'h0000ABCD, Page=0 before the first frame boundary. Second frame shows:
   - Digits 0..3 = d,C,b,A (0100001, 1000110, 0000011, 0001000).
   - Digits 4..7 = 0,1,0,0.
4. Page and mid-frame change: set Page=1 mid-frame 2, with the same values as scenario 3.
   - Frame 2 is unchanged.
   - Frame 3 digits 0..3 = 0,0,0,0; digits 4..7 = 0,4,0,0 (digit 5 Seg=0011001).
5. Freeze: assert Freeze across a frame boundary and change WriteData to 32'h00001234. Displayed data stays ABCD. After Freeze drops, the next frame shows 4,3,2,1 on digits 0..3.
6. Mid-frame reset: pulse Rst for 1 cycle while idx=5 -> An=8'hFF on that edge. The scan restarts at FE, and Seg shows 0 until the next frame boundary.
